// File: rtl/me_iddmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : me_iddmm_pkg
// Description : Shared defaults and host FSM state type for the IDDMM host.
// Revision    : 1.0 - initial release
// ============================================================================
package me_iddmm_pkg;

    localparam int ME_K = 128;
    localparam int ME_N = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        GAP      = 3'd2,
        SEND     = 3'd3,
        WAIT_RES = 3'd4,
        RECV     = 3'd5,
        DONE     = 3'd6
    } me_host_state_t;

    // Counter width helper that never collapses to zero bits.
    function automatic int min1_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_iddmm_host.sv
`default_nettype none
// ============================================================================
// Module      : me_iddmm_host
// Description : Host initiator for me_iddmm_top: serialises two operands
//               LSW-first, then assembles the N-word result.
// Revision    : 1.0 - initial release
// ============================================================================
module me_iddmm_host
    import me_iddmm_pkg::*;
#(
    parameter int K         = ME_K,
    parameter int N         = ME_N,
    parameter int START_GAP = 10,
    parameter int TIMEOUT   = 2**20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [K*N-1:0] req_x,
    input  logic [K*N-1:0] req_y,
    output logic           resp_valid,
    output logic           resp_error,
    output logic [K*N-1:0] resp_result,
    output logic           me_start,
    output logic [K-1:0]   me_x,
    output logic           me_x_valid,
    output logic [K-1:0]   me_y,
    output logic           me_y_valid,
    input  logic [K-1:0]   me_result,
    input  logic           me_valid
);

    localparam int c_WORD_W = $clog2(N + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT + 1);
    localparam int c_GAP_W  = min1_clog2(START_GAP);
    localparam int c_IDX_W  = min1_clog2(N);

    localparam logic [c_WORD_W-1:0] c_N_BEATS  = c_WORD_W'(N);
    localparam logic [c_WORD_W-1:0] c_N_LAST   = c_WORD_W'(N - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LOAD = c_GAP_W'(START_GAP - 1);

    me_host_state_t        r_state,  w_state_nxt;
    logic [c_GAP_W-1:0]    r_gcnt,   w_gcnt_nxt;
    logic [c_WORD_W-1:0]   r_wcnt,   w_wcnt_nxt;
    logic [c_TMO_W-1:0]    r_tcnt,   w_tcnt_nxt;
    logic [K*N-1:0]        r_x_sh;
    logic [K*N-1:0]        r_y_sh;
    logic [K-1:0]          r_res [N];

    logic                  w_load;
    logic                  w_beat_word;
    logic                  w_capture;
    logic                  w_timeout;

    // r_wcnt counts beats in SEND and received words in WAIT_RES/RECV.
    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_wcnt_nxt  = r_wcnt;
        w_tcnt_nxt  = r_tcnt;
        w_load      = 1'b0;
        w_beat_word = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    w_load      = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_gcnt_nxt  = c_GAP_LOAD;
                w_state_nxt = GAP;
            end
            GAP: begin
                if (r_gcnt == '0) begin
                    w_beat_word = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = SEND;
                end else begin
                    w_gcnt_nxt = r_gcnt - 1'b1;
                end
            end
            SEND: begin
                if (r_wcnt == c_N_BEATS) begin
                    w_wcnt_nxt  = '0;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = WAIT_RES;
                end else begin
                    // The beat after word N-1 is the mandatory all-zero trailer.
                    w_wcnt_nxt  = r_wcnt + 1'b1;
                    w_beat_word = (r_wcnt != c_N_LAST);
                end
            end
            WAIT_RES, RECV: begin
                w_tcnt_nxt = r_tcnt + 1'b1;
                if (me_valid) begin
                    w_capture  = 1'b1;
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
                if (me_valid && (r_wcnt == c_N_LAST)) begin
                    w_state_nxt = DONE;
                end else if (r_tcnt == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end else if (me_valid) begin
                    w_state_nxt = RECV;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gcnt  <= '0;
            r_wcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_sh     <= '0;
            r_y_sh     <= '0;
            for (int i = 0; i < N; i++) begin
                r_res[i] <= '0;
            end
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            me_start   <= 1'b0;
            me_x       <= '0;
            me_x_valid <= 1'b0;
            me_y       <= '0;
            me_y_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_x_sh <= req_x;
                r_y_sh <= req_y;
                for (int i = 0; i < N; i++) begin
                    r_res[i] <= '0;
                end
            end else if (w_beat_word) begin
                r_x_sh <= r_x_sh >> K;
                r_y_sh <= r_y_sh >> K;
            end
            if (w_capture) begin
                r_res[r_wcnt[c_IDX_W-1:0]] <= me_result;
            end
            req_ready  <= (w_state_nxt == IDLE);
            resp_valid <= (w_state_nxt == DONE);
            resp_error <= w_timeout;
            me_start   <= (w_state_nxt == START);
            me_x_valid <= (w_state_nxt == SEND);
            me_y_valid <= (w_state_nxt == SEND);
            me_x       <= w_beat_word ? r_x_sh[K-1:0] : '0;
            me_y       <= w_beat_word ? r_y_sh[K-1:0] : '0;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_result
        assign resp_result[g*K +: K] = r_res[g];
    end

endmodule
`default_nettype wire
